// File: rtl/ov_pixel_capture_pkg.sv
// ov_capture_pkg: capture states, frame sizing, RGB565->RGB444 conversion and colour-bar table
package ov_capture_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, ACTIVE} cap_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic int frame_pixels(input int h, input int v);
        return h * v;
    endfunction

    function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

    function automatic logic [11:0] bar_colour(input int col, input int h);
        int idx;
        idx = col * 8 / h;
        return BAR_RGB[idx > 7 ? 3'd7 : 3'(idx)];
    endfunction

endpackage

// File: rtl/ov_pixel_capture_if.sv
// ov_pixel_capture_if: OV2640 parallel bus in, frame BRAM write port out
interface ov_pixel_capture_if #(
    parameter int ADDR_W = 20
);
    logic              ov_pclk;
    logic              ov_href;
    logic              ov_vsync;
    logic [7:0]        ov_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;

    modport master (
        input  ov_pclk, ov_href, ov_vsync, ov_data,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output ov_pclk, ov_href, ov_vsync, ov_data,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ov_pixel_capture_sig_sync.sv
// ov_sig_sync: 2-flop synchroniser with a third register for rise/fall detection
module ov_sig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else sr <= {sr[1:0], d};

    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/ov_pixel_capture.sv
// ov_pixel_capture: OV2640 byte-pair capture to linear RGB444 BRAM writes; CAPTURE_TESTPAT_EN swaps pixels for colour bars
module ov_pixel_capture
    import ov_capture_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ADDR_W      = 20,
    parameter int SKIP_FRAMES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    ov_pixel_capture_if.master    cam,
    output logic                  frame_done,
    output logic                  capturing,
    output logic                  overflow
);
    localparam logic [ADDR_W:0] N_PIX = (ADDR_W + 1)'(frame_pixels(H_ACTIVE, V_ACTIVE));

    logic pc_lvl, pc_rise, pc_fall;
    logic hr, hr_rise, hr_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic [7:0] d1, d2, hi;
    cap_state_e state_q, state_d;
    logic [7:0] skip_cnt;
    logic settled, phase, frame_start, frame_end, pix_done, pix_ok;
    logic [ADDR_W:0] pix_cnt;
    logic [11:0] pix, wr_data;
    logic wr_en, unused_ok;

    ov_sig_sync u_pclk  (.clk, .rst_n, .d(cam.ov_pclk),  .q(pc_lvl), .rise(pc_rise), .fall(pc_fall));
    ov_sig_sync u_href  (.clk, .rst_n, .d(cam.ov_href),  .q(hr),     .rise(hr_rise), .fall(hr_fall));
    ov_sig_sync u_vsync (.clk, .rst_n, .d(cam.ov_vsync), .q(vs_lvl), .rise(vs_rise), .fall(vs_fall));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = WAIT_VS;
            WAIT_VS: if (vs_fall) state_d = (settled || SKIP_FRAMES == 0) ? ACTIVE : SKIP;
            SKIP:    if (vs_fall && skip_cnt >= 8'(SKIP_FRAMES)) state_d = ACTIVE;
            default: if (vs_rise) state_d = WAIT_VS;
        endcase
        if (!en) state_d = IDLE;
        frame_start = state_q != ACTIVE && state_d == ACTIVE;
        frame_end   = en && state_q == ACTIVE && vs_rise;
        pix_done    = en && state_q == ACTIVE && pc_rise && hr && phase;
        pix_ok      = pix_done && pix_cnt < N_PIX;
    end

    // settled remembers that the post-enable skip has been served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            {d2, d1}   <= '0;
            hi         <= '0;
            settled    <= 1'b0;
            skip_cnt   <= '0;
            phase      <= 1'b0;
            pix_cnt    <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
        end else begin
            state_q    <= state_d;
            {d2, d1}   <= {d1, cam.ov_data};
            settled    <= state_d != IDLE && (settled || frame_start);
            skip_cnt   <= state_q == WAIT_VS ? 8'd1 : (state_q == SKIP && vs_fall) ? skip_cnt + 8'd1 : skip_cnt;
            phase      <= (state_d == IDLE || frame_start || !hr) ? 1'b0 : (state_q == ACTIVE && pc_rise) ? ~phase : phase;
            if (state_q == ACTIVE && pc_rise && hr && !phase) hi <= d2;
            pix_cnt    <= (state_d == IDLE || frame_start) ? '0 : wr_en ? pix_cnt + 1'b1 : pix_cnt;
            overflow   <= frame_start ? 1'b0 : overflow | (pix_done && !pix_ok);
            frame_done <= frame_end;
            wr_en      <= pix_ok;
            if (pix_ok) wr_data <= pix;
        end
    end

`ifdef CAPTURE_TESTPAT_EN
    logic [15:0] col;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) col <= '0;
        else col <= (state_d == IDLE || frame_start || hr_fall) ? '0 : pix_done ? col + 16'd1 : col;

    assign pix       = bar_colour(int'(col), H_ACTIVE);
    assign unused_ok = &{1'b0, pc_lvl, pc_fall, hr_rise, vs_lvl, hi};
`else
    assign pix       = rgb565_to_444(hi, d2);
    assign unused_ok = &{1'b0, pc_lvl, pc_fall, hr_rise, vs_lvl, hr_fall};
`endif

    assign capturing   = state_q == ACTIVE;
    assign cam.wr_en   = wr_en;
    assign cam.wr_addr = pix_cnt[ADDR_W-1:0];
    assign cam.wr_data = wr_data;
endmodule

// File: tb/tb_ov_pixel_capture.sv
// tb_ov_pixel_capture: directed capture sequence on a small 8x4 frame with a write scoreboard
module tb_ov_pixel_capture;
    localparam int H = 8, V = 4, AW = 6, N = H * V;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [11:0]   d;
    } px_t;

    logic clk, rst_n, en, frame_done, capturing, overflow;
    int n_assert = 0, n_fail = 0, exp_addr = 0, fd_cnt = 0, wr_cnt = 0, w0;
    logic [AW-1:0] last_addr = '0;
    px_t sb[$];
    logic [7:0] line_q[$];

    ov_pixel_capture_if #(.ADDR_W(AW)) bus ();

    ov_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cam(bus),
        .frame_done(frame_done), .capturing(capturing), .overflow(overflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_px(input logic [7:0] h, input logic [7:0] l);
        int r, g, b;
        r = h / 16;
        g = (h % 8) * 2 + l / 128;
        b = (l / 2) % 16;
        if (exp_addr < N) begin
            sb.push_back('{AW'(exp_addr), 12'(r * 256 + g * 16 + b)});
            exp_addr++;
        end
    endtask

    task automatic rand_line(input int n);
        line_q.delete();
        repeat (n) line_q.push_back(8'($urandom));
    endtask

    task automatic send_bytes(input bit cap);
        for (int i = 0; i < line_q.size(); i++) begin
            bus.ov_data = line_q[i];
            if (cap && i[0]) expect_px(line_q[i-1], line_q[i]);
            #27 bus.ov_pclk = 1;
            #27 bus.ov_pclk = 0;
        end
    endtask

    task automatic send_line(input bit cap);
        bus.ov_href = 1;
        #13;
        send_bytes(cap);
        #13 bus.ov_href = 0;
        #80;
    endtask

    task automatic vs_fall(input bit cap);
        bus.ov_vsync = 0;
        if (cap) exp_addr = 0;
        #200;
        settle(1);
    endtask

    task automatic vs_rise();
        bus.ov_vsync = 1;
        #200;
        settle(1);
    endtask

    always @(negedge clk) begin
        px_t e;
        if (frame_done) fd_cnt++;
        if (bus.wr_en) begin
            wr_cnt++;
            last_addr = bus.wr_addr;
            chk("wr_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                chk("wr_data", 32'(bus.wr_data), 32'(e.d));
            end
        end
    end

    initial begin
        rst_n = 0; en = 0;
        bus.ov_pclk = 0; bus.ov_href = 0; bus.ov_vsync = 1; bus.ov_data = '0;
        settle(3);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_capturing", capturing, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1;
        settle(2);
        en = 1;
        settle(4);
        chk("idle_capturing", capturing, 0);

        for (int f = 0; f < 2; f++) begin
            vs_fall(0);
            chk("skip_capturing", capturing, 0);
            rand_line(16); send_line(0);
            rand_line(16); send_line(0);
            vs_rise();
        end
        chk("skip_frame_done", fd_cnt, 0);
        chk("skip_writes", wr_cnt, 0);

        vs_fall(1);
        chk("third_frame_capturing", capturing, 1);
        line_q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
        send_line(1);
        vs_rise();
        chk("line_frame_done", fd_cnt, 1);
        chk("line_drain", sb.size(), 0);
        chk("line_wr_addr", bus.wr_addr, 3);
        chk("line_back_to_wait", capturing, 0);

        vs_fall(1);
        w0 = wr_cnt;
        for (int l = 0; l < V; l++) begin rand_line(2 * H); send_line(1); end
        vs_rise();
        chk("full_writes", wr_cnt - w0, N);
        chk("full_last_addr", last_addr, N - 1);
        chk("full_overflow", overflow, 0);
        chk("full_frame_done", fd_cnt, 2);
        chk("full_drain", sb.size(), 0);

        vs_fall(1);
        w0 = wr_cnt;
        for (int l = 0; l < V; l++) begin rand_line(2 * H); send_line(1); end
        chk("ovf_not_yet", overflow, 0);
        rand_line(2 * H); send_line(1);
        chk("ovf_set", overflow, 1);
        chk("ovf_addr_hold", bus.wr_addr, N);
        vs_rise();
        chk("ovf_writes", wr_cnt - w0, N);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_frame_done", fd_cnt, 3);

        vs_fall(1);
        chk("ovf_cleared", overflow, 0);
        chk("new_frame_addr", bus.wr_addr, 0);
        w0 = wr_cnt;
        rand_line(5); send_line(1);
        rand_line(4); send_line(1);
        vs_rise();
        chk("odd_writes", wr_cnt - w0, 4);
        chk("odd_drain", sb.size(), 0);
        chk("odd_frame_done", fd_cnt, 4);

        vs_fall(1);
        bus.ov_href = 1;
        #13;
        rand_line(4); send_bytes(1);
        #60;
        en = 0;
        settle(2);
        chk("en_drop_capturing", capturing, 0);
        chk("en_drop_addr", bus.wr_addr, 0);
        chk("en_drop_drain", sb.size(), 0);
        rand_line(6); send_bytes(0);
        en = 1;
        rand_line(4); send_bytes(0);
        #13 bus.ov_href = 0;
        #80;
        vs_rise();
        chk("en_drop_no_frame_done", fd_cnt, 4);

        for (int f = 0; f < 2; f++) begin
            vs_fall(0);
            chk("reskip_capturing", capturing, 0);
            rand_line(2 * H); send_line(0);
            vs_rise();
        end
        vs_fall(1);
        chk("reenable_capturing", capturing, 1);
        chk("reenable_addr", bus.wr_addr, 0);
        rand_line(2 * H); send_line(1);
        vs_rise();
        chk("reenable_last_addr", last_addr, H - 1);
        chk("reenable_drain", sb.size(), 0);
        chk("reenable_frame_done", fd_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
